// File: rtl/simmem_release_scheduler.sv
// Per-slot release scheduler for one response bank of the simulated memory
// controller. A (slot, delay) request is accepted into an idle slot, the
// delay is counted down, and the slot's release-enable bit is held high
// until the bank reports that slot released.
module simmem_release_scheduler #(
  parameter int NumSlots = 8,
  parameter int DelayW   = 8,
  parameter int IidW     = $clog2(NumSlots)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sched_valid_i,
  output logic                sched_ready_o,
  input  logic [IidW-1:0]     sched_iid_i,
  input  logic [DelayW-1:0]   sched_delay_i,
  output logic [NumSlots-1:0] release_en_o,
  input  logic [NumSlots-1:0] released_addr_onehot_i,
  output logic [IidW:0]       num_pending_o,
  output logic                err_o
);

  localparam int CntW = IidW + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_ARMED    = 2'd2
  } slot_state_e;

  slot_state_e       slot_state [NumSlots];
  logic [DelayW-1:0] slot_cnt   [NumSlots];

  logic                accept;
  logic [NumSlots-1:0] accept_vec;
  logic [NumSlots-1:0] armed_vec;
  logic [NumSlots-1:0] release_hit;
  logic                bad_release;
  logic [CntW-1:0]     release_cnt;

  // Number of set bits in a slot vector, sized to hold NumSlots.
  function automatic logic [CntW-1:0] popcount(input logic [NumSlots-1:0] v);
    logic [CntW-1:0] sum;
    sum = '0;
    for (int i = 0; i < NumSlots; i++) begin
      sum = sum + CntW'(v[i]);
    end
    return sum;
  endfunction

  // Ready reflects the addressed slot being idle; iids that match no slot
  // are never ready, so they can never be accepted.
  always_comb begin
    sched_ready_o = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      if (sched_iid_i == IidW'(i)) begin
        sched_ready_o = (slot_state[i] == ST_IDLE);
      end
    end
  end

  assign accept = sched_valid_i && sched_ready_o;

  // Decode accept per slot and classify bank releases as legal or stray.
  always_comb begin
    accept_vec = '0;
    armed_vec  = '0;
    for (int i = 0; i < NumSlots; i++) begin
      accept_vec[i] = accept && (sched_iid_i == IidW'(i));
      armed_vec[i]  = (slot_state[i] == ST_ARMED);
    end
    release_hit = armed_vec & released_addr_onehot_i;
    bad_release = |(released_addr_onehot_i & ~armed_vec);
    release_cnt = popcount(release_hit);
  end

  assign release_en_o = armed_vec;

  // Per-slot lifecycle: idle -> (counting) -> armed -> idle on bank release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) begin
        slot_state[i] <= ST_IDLE;
        slot_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        case (slot_state[i])
          ST_IDLE: begin
            if (accept_vec[i]) begin
              if (sched_delay_i == '0) begin
                slot_state[i] <= ST_ARMED;
              end else begin
                slot_state[i] <= ST_COUNTING;
                slot_cnt[i]   <= sched_delay_i - DelayW'(1);
              end
            end
          end
          ST_COUNTING: begin
            if (slot_cnt[i] == '0) begin
              slot_state[i] <= ST_ARMED;
            end else begin
              slot_cnt[i] <= slot_cnt[i] - DelayW'(1);
            end
          end
          ST_ARMED: begin
            if (released_addr_onehot_i[i]) begin
              slot_state[i] <= ST_IDLE;
            end
          end
          default: begin
            slot_state[i] <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Pending count tracks accepts in and legal releases out; stray releases
  // latch the sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      num_pending_o <= '0;
      err_o         <= 1'b0;
    end else begin
      num_pending_o <= num_pending_o + CntW'(accept) - release_cnt;
      err_o         <= err_o | bad_release;
    end
  end

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Randomized and directed bench for simmem_release_scheduler, compared
// against a timestamp-based reference model of slot arming and release.
module tb_simmem_release_scheduler;

  localparam int NS = 8;
  localparam int DW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          sched_valid;
  logic          sched_ready;
  logic [IW-1:0] sched_iid;
  logic [DW-1:0] sched_delay;
  logic [NS-1:0] release_en;
  logic [NS-1:0] released;
  logic [IW:0]   num_pending;
  logic          err;

  always #5 clk = ~clk;

  simmem_release_scheduler #(
    .NumSlots(NS),
    .DelayW  (DW)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .sched_valid_i         (sched_valid),
    .sched_ready_o         (sched_ready),
    .sched_iid_i           (sched_iid),
    .sched_delay_i         (sched_delay),
    .release_en_o          (release_en),
    .released_addr_onehot_i(released),
    .num_pending_o         (num_pending),
    .err_o                 (err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a slot is pending from accept until its legal release,
  // and is armed once the edge count reaches its arm timestamp.
  bit     pend   [NS];
  longint arm_at [NS];
  bit     m_err;
  longint n;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_armed(input int i, input longint k);
    return pend[i] && (k >= arm_at[i]);
  endfunction

  function automatic logic [NS-1:0] m_en();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_armed(i, n);
    return v;
  endfunction

  function automatic int m_count();
    int c;
    c = 0;
    for (int i = 0; i < NS; i++) c += int'(pend[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      pend[i]   = 1'b0;
      arm_at[i] = 0;
    end
    m_err = 1'b0;
    n     = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input bit v, input int iid, input int d, input logic [NS-1:0] rel);
    bit acc;
    sched_valid = v;
    sched_iid   = iid[IW-1:0];
    sched_delay = d[DW-1:0];
    released    = rel;
    #1;
    check_val("ready", 32'(sched_ready), 32'(!pend[iid]));
    acc = v && !pend[iid];
    @(posedge clk);
    n++;
    for (int i = 0; i < NS; i++) begin
      if (rel[i]) begin
        if (m_armed(i, n - 1)) pend[i] = 1'b0;
        else                   m_err   = 1'b1;
      end
    end
    if (acc) begin
      pend[iid]   = 1'b1;
      arm_at[iid] = n + d;
    end
    @(negedge clk);
    check_val("release_en", 32'(release_en), 32'(m_en()));
    check_val("num_pending", 32'(num_pending), m_count());
    check_val("err", 32'(err), 32'(m_err));
  endtask

  // Asynchronous reset asserted between clock edges, entered at a falling edge.
  task automatic do_reset();
    sched_valid = 1'b0;
    released    = '0;
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_en", 32'(release_en), 0);
    check_val("rst_pending", 32'(num_pending), 0);
    check_val("rst_err", 32'(err), 0);
    check_val("rst_ready", 32'(sched_ready), 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  bit            hv;
  int            hi;
  int            hd;
  int            j;
  logic [NS-1:0] rel;

  initial begin
    rst         = 1'b1;
    sched_valid = 1'b0;
    sched_iid   = '0;
    sched_delay = '0;
    released    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("init_en", 32'(release_en), 0);
    check_val("init_pending", 32'(num_pending), 0);
    check_val("init_err", 32'(err), 0);
    rst = 1'b0;

    // Zero-delay schedule arms after one cycle; release clears it.
    cycle(1, 3, 0, '0);
    check_val("s1_en", 32'(release_en), 32'h08);
    check_val("s1_pend1", 32'(num_pending), 1);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, 8'h08);
    check_val("s1_en_clr", 32'(release_en), 0);
    check_val("s1_pend0", 32'(num_pending), 0);

    // Two overlapping countdowns of different lengths.
    do_reset();
    cycle(1, 0, 5, '0);
    cycle(1, 1, 2, '0);
    check_val("s2_pend", 32'(num_pending), 2);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    check_val("s2_bit1", 32'(release_en), 32'h02);
    cycle(0, 0, 0, '0);
    check_val("s2_bit1_only", 32'(release_en), 32'h02);
    cycle(0, 0, 0, '0);
    check_val("s2_both", 32'(release_en), 32'h03);
    cycle(0, 0, 0, 8'h01);
    cycle(0, 0, 0, 8'h02);

    // Fill every slot, stall on a busy iid, then free it.
    do_reset();
    for (int i = 0; i < NS; i++) cycle(1, i, 10, '0);
    check_val("s3_full", 32'(num_pending), NS);
    repeat (12) cycle(1, 2, 10, '0);
    check_val("s3_stalled", 32'(sched_ready), 0);
    check_val("s3_all_armed", 32'(release_en), 32'hFF);
    cycle(1, 2, 10, 8'h04);
    check_val("s3_freed", 32'(num_pending), NS - 1);
    cycle(1, 2, 10, '0);
    check_val("s3_refill", 32'(num_pending), NS);

    // Accept one slot while another is released in the same cycle.
    do_reset();
    cycle(1, 5, 0, '0);
    cycle(1, 4, 3, 8'h20);
    check_val("s4_pend", 32'(num_pending), 1);
    check_val("s4_bit5_clr", 32'(release_en), 0);
    repeat (3) cycle(0, 0, 0, '0);
    check_val("s4_bit4", 32'(release_en), 32'h10);

    // Stray release during countdown sets the sticky error only.
    do_reset();
    cycle(1, 6, 4, '0);
    cycle(0, 0, 0, 8'h40);
    check_val("s5_err", 32'(err), 1);
    repeat (3) cycle(0, 0, 0, '0);
    check_val("s5_armed", 32'(release_en), 32'h40);
    check_val("s5_err_sticky", 32'(err), 1);

    // Asynchronous reset mid-count, then a fresh zero-delay schedule.
    do_reset();
    cycle(1, 0, 20, '0);
    cycle(1, 1, 20, '0);
    cycle(1, 2, 20, '0);
    repeat (3) cycle(0, 0, 0, '0);
    do_reset();
    cycle(1, 1, 0, '0);
    check_val("s6_rearm", 32'(release_en), 32'h02);

    // Randomized traffic with stalls, mostly legal releases, periodic resets.
    do_reset();
    hv = 1'b0;
    hi = 0;
    hd = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 700 == 699) begin
        do_reset();
        hv = 1'b0;
      end
      if (!hv) begin
        hv = ($urandom % 2) == 0;
        hi = int'($urandom % NS);
        hd = (($urandom % 16) == 0) ? 255 : int'($urandom % 8);
      end
      rel = '0;
      if (($urandom % 3) == 0) begin
        j = int'($urandom % NS);
        if (m_armed(j, n) || (($urandom % 25) == 0)) rel[j] = 1'b1;
      end
      if (hv && !pend[hi]) begin
        cycle(1, hi, hd, rel);
        hv = 1'b0;
      end else begin
        cycle(hv, hi, hd, rel);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
